edge_bit_packer: RTL and testbench



---
 rtl/edge_pkg.sv | 19 +
 rtl/bit_shift_pack.sv | 56 +++++
 rtl/edge_bit_packer.sv | 172 +++++++++++++++++
 tb/tb_edge_bit_packer.sv | 366 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/edge_pkg.sv
// Shared definitions for the 1-bit edge pixel packer: default image
// geometry, derived frame constants and the packer FSM encoding.
package edge_pkg;

  localparam int IMG_W_DFLT = 640;
  localparam int IMG_H_DFLT = 480;
  localparam int DW_DFLT    = 16;

  // Pixels per frame and output words per frame for the default geometry.
  localparam int TOTAL     = IMG_W_DFLT * IMG_H_DFLT;
  localparam int WORDS     = (TOTAL + DW_DFLT - 1) / DW_DFLT;
  localparam int PIX_CNT_W = $clog2(TOTAL + 1);

  typedef enum logic {
    IDLE = 1'b0,
    PACK = 1'b1
  } state_t;

endpackage

// File: rtl/bit_shift_pack.sv
// MSB-first serial-to-parallel shift register with bit counter.
// clr discards the held partial word in the same cycle as a shift.
// The word output always includes bit_in and is left-aligned, so a
// partial word comes out zero-padded in its LSBs.
module bit_shift_pack
  import edge_pkg::*;
#(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          clr,
  input  logic          shift_en,
  input  logic          flush,
  input  logic          bit_in,
  output logic [DW-1:0] word,
  output logic          full
);

  localparam int CW = $clog2(DW);

  logic [DW-2:0] sr;
  logic [DW-2:0] eff_sr;
  logic [CW-1:0] bit_cnt;
  logic [CW-1:0] eff_cnt;
  logic [DW-1:0] packed_bits;

  // Current contents (after optional clear) with the incoming bit appended.
  always_comb begin
    eff_sr      = clr ? '0 : sr;
    eff_cnt     = clr ? '0 : bit_cnt;
    packed_bits = {eff_sr, bit_in};
    full        = (eff_cnt == CW'(DW - 1));
    word        = packed_bits << (CW'(DW - 1) - eff_cnt);
  end

  // Shift one bit per enable; restart after a full or flushed word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sr      <= '0;
      bit_cnt <= '0;
    end else if (shift_en) begin
      if (full || flush) begin
        sr      <= '0;
        bit_cnt <= '0;
      end else begin
        sr      <= packed_bits[DW-2:0];
        bit_cnt <= eff_cnt + CW'(1);
      end
    end else if (clr) begin
      sr      <= '0;
      bit_cnt <= '0;
    end
  end

endmodule

// File: rtl/edge_bit_packer.sv
// Packs the serial 1-bit edge stream into DW-bit MSB-first words for the
// SDRAM write path, checks frame length against IMG_W*IMG_H and zero-pads
// the final word of a short frame. DW must be 8, 16 or 32.
// Optional feature: define EDGE_PACK_STAT_EN to add the edge_cnt output
// (count of edge pixels packed in the frame, latched at eop).
module edge_bit_packer
  import edge_pkg::*;
#(
  parameter int IMG_W = IMG_W_DFLT,
  parameter int IMG_H = IMG_H_DFLT,
  parameter int DW    = DW_DFLT
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          din,
  input  logic          din_vld,
  input  logic          din_sop,
  input  logic          din_eop,
  output logic [DW-1:0] dout,
  output logic          dout_vld,
  output logic          dout_sop,
  output logic          dout_eop,
  output logic          err
`ifdef EDGE_PACK_STAT_EN
  ,
  output logic [19:0]   edge_cnt
`endif
);

  localparam int FRAME_PIX = IMG_W * IMG_H;
  localparam int CNT_W     = $clog2(FRAME_PIX + 1);
  localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(FRAME_PIX - 1);

  state_t           state, nxt_state;
  logic [CNT_W-1:0] pix_cnt, nxt_cnt, cnt_b;
  logic             first_word, nxt_first, first_b;
  logic             drop, nxt_drop, drop_b;
  logic             start, active, pack_clr;
  logic             shift_en, flush;
  logic             emit, emit_sop, emit_eop, err_nxt;
  logic [DW-1:0]    pack_word;
  logic             pack_full;

  logic [DW-1:0]    dout_p1;
  logic             dout_vld_p1, dout_sop_p1, dout_eop_p1, err_p1;

  // A sop pixel always starts a fresh frame, whatever the current state.
  assign start  = din_vld & din_sop;
  assign active = start | (state == PACK);
  // Discard the held partial word on restart, or when an overflowed frame ends.
  assign pack_clr = start | (din_vld & din_eop & drop & (state == PACK));

  bit_shift_pack #(
    .DW(DW)
  ) u_pack (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr      (pack_clr),
    .shift_en (shift_en),
    .flush    (flush),
    .bit_in   (din),
    .word     (pack_word),
    .full     (pack_full)
  );

  // Frame FSM: packing, word emit, length check, overflow drop, restart.
  always_comb begin
    cnt_b     = start ? '0 : pix_cnt;
    first_b   = start ? 1'b1 : first_word;
    drop_b    = start ? 1'b0 : drop;
    nxt_state = state;
    nxt_cnt   = pix_cnt;
    nxt_first = first_word;
    nxt_drop  = drop;
    shift_en  = 1'b0;
    flush     = 1'b0;
    emit      = 1'b0;
    emit_sop  = 1'b0;
    emit_eop  = 1'b0;
    err_nxt   = start & (state == PACK);
    if (din_vld && active) begin
      nxt_state = PACK;
      nxt_cnt   = cnt_b;
      nxt_first = first_b;
      nxt_drop  = drop_b;
      if (drop_b) begin
        // Overflowed frame: swallow pixels until eop, which emits nothing.
        if (din_eop) begin
          nxt_state = IDLE;
          nxt_drop  = 1'b0;
          nxt_cnt   = '0;
        end
      end else if (din_eop) begin
        shift_en  = 1'b1;
        flush     = 1'b1;
        emit      = 1'b1;
        emit_sop  = first_b;
        emit_eop  = 1'b1;
        nxt_state = IDLE;
        nxt_cnt   = '0;
        nxt_first = 1'b0;
        if (cnt_b != LAST_IDX) err_nxt = 1'b1;
      end else if (cnt_b == LAST_IDX) begin
        // Last legal pixel arrived without eop: drop it and the rest.
        err_nxt  = 1'b1;
        nxt_drop = 1'b1;
      end else begin
        shift_en = 1'b1;
        nxt_cnt  = cnt_b + CNT_W'(1);
        if (pack_full) begin
          emit      = 1'b1;
          emit_sop  = first_b;
          nxt_first = 1'b0;
        end
      end
    end
  end

  // Stage p1: control state and registered word/strobe outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      pix_cnt     <= '0;
      first_word  <= 1'b0;
      drop        <= 1'b0;
      dout_p1     <= '0;
      dout_vld_p1 <= 1'b0;
      dout_sop_p1 <= 1'b0;
      dout_eop_p1 <= 1'b0;
      err_p1      <= 1'b0;
    end else begin
      state       <= nxt_state;
      pix_cnt     <= nxt_cnt;
      first_word  <= nxt_first;
      drop        <= nxt_drop;
      dout_vld_p1 <= emit;
      dout_sop_p1 <= emit & emit_sop;
      dout_eop_p1 <= emit & emit_eop;
      err_p1      <= err_nxt;
      if (emit) dout_p1 <= pack_word;
    end
  end

  assign dout     = dout_p1;
  assign dout_vld = dout_vld_p1;
  assign dout_sop = dout_sop_p1;
  assign dout_eop = dout_eop_p1;
  assign err      = err_p1;

`ifdef EDGE_PACK_STAT_EN
  logic [19:0] edge_acc, nxt_edge, edge_p1;
  logic        frame_end;

  // Only pixels that actually enter the shift register are counted.
  assign nxt_edge  = (start ? 20'd0 : edge_acc) + 20'(shift_en & din);
  assign frame_end = din_vld & din_eop & active;

  // Stage p1: running edge count, snapshot presented with the eop word.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      edge_acc <= '0;
      edge_p1  <= '0;
    end else begin
      edge_acc <= nxt_edge;
      if (frame_end) edge_p1 <= nxt_edge;
    end
  end

  assign edge_cnt = edge_p1;
`endif

endmodule

// File: tb/tb_edge_bit_packer.sv
// Bench for edge_bit_packer: two instances (16-pixel and 64-pixel frames)
// share one input stream and are compared every cycle against a frame-level
// reference model.
module tb_edge_bit_packer;

  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic din = 1'b0, din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0;

  always #5 clk = ~clk;

  logic [DW-1:0] dout_a, dout_b;
  logic dvld_a, dsop_a, deop_a, err_a;
  logic dvld_b, dsop_b, deop_b, err_b;
  logic [19:0] ecnt_a, ecnt_b;

  edge_bit_packer #(.IMG_W(8), .IMG_H(2), .DW(DW)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .din_sop(din_sop), .din_eop(din_eop), .dout(dout_a),
    .dout_vld(dvld_a), .dout_sop(dsop_a), .dout_eop(deop_a), .err(err_a)
`ifdef EDGE_PACK_STAT_EN
    , .edge_cnt(ecnt_a)
`endif
  );

  edge_bit_packer #(.IMG_W(8), .IMG_H(8), .DW(DW)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din), .din_vld(din_vld),
    .din_sop(din_sop), .din_eop(din_eop), .dout(dout_b),
    .dout_vld(dvld_b), .dout_sop(dsop_b), .dout_eop(deop_b), .err(err_b)
`ifdef EDGE_PACK_STAT_EN
    , .edge_cnt(ecnt_b)
`endif
  );

`ifndef EDGE_PACK_STAT_EN
  assign ecnt_a = '0;
  assign ecnt_b = '0;
`endif

  logic [39:0] obs [2];
  assign obs[0] = {dvld_a, dsop_a, deop_a, err_a, dout_a, ecnt_a};
  assign obs[1] = {dvld_b, dsop_b, deop_b, err_b, dout_b, ecnt_b};

  int vectors = 0;
  int miscompares = 0;

  // ---------------- reference model (frame level) ----------------
  int          tot [2];
  bit          fb [2][128];
  int          nfb [2];
  int          nwords [2];
  bit          in_frame [2];
  bit          dropping [2];
  logic [DW-1:0] hold [2];
  logic [19:0] elat [2];
  logic [39:0] expv [2];

  function automatic int popc(input int i);
    int c = 0;
    for (int k = 0; k < nfb[i]; k++) c += int'(fb[i][k]);
    return c;
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 2; i++) begin
      nfb[i] = 0; nwords[i] = 0; in_frame[i] = 0; dropping[i] = 0;
      hold[i] = '0; elat[i] = '0; expv[i] = '0;
    end
  endfunction

  function automatic void model_step(input int i, input logic v, input logic s,
                                     input logic e, input logic d);
    logic vo, so, eo, er;
    int n;
    logic [DW-1:0] w;
    logic [19:0] ev;
    vo = 0; so = 0; eo = 0; er = 0;
    if (v) begin
      if (s) begin
        if (in_frame[i]) er = 1;
        nfb[i] = 0; nwords[i] = 0; dropping[i] = 0; in_frame[i] = 1;
      end
      if (in_frame[i]) begin
        if (dropping[i]) begin
          if (e) begin in_frame[i] = 0; elat[i] = 20'(popc(i)); end
        end else if (!e && nfb[i] == tot[i] - 1) begin
          er = 1; dropping[i] = 1;
        end else begin
          fb[i][nfb[i]] = d;
          nfb[i]++;
          if (e || (nfb[i] % DW) == 0) begin
            n = nfb[i] % DW;
            if (n == 0) n = DW;
            w = '0;
            for (int k = 0; k < n; k++) w[DW-1-k] = fb[i][nfb[i]-n+k];
            vo = 1; so = (nwords[i] == 0); eo = e;
            nwords[i]++;
            hold[i] = w;
          end
          if (e) begin
            if (nfb[i] != tot[i]) er = 1;
            in_frame[i] = 0;
            elat[i] = 20'(popc(i));
          end
        end
      end
    end
`ifdef EDGE_PACK_STAT_EN
    ev = elat[i];
`else
    ev = '0;
`endif
    expv[i] = {vo, so, eo, er, hold[i], ev};
  endfunction

  // ---------------- stimulus plumbing ----------------
  typedef struct packed { logic v; logic s; logic e; logic d; } stim_t;
  stim_t sq[$];

  task automatic apply(input stim_t st);
    din_vld = st.v; din_sop = st.s; din_eop = st.e; din = st.d;
    model_step(0, st.v, st.s, st.e, st.d);
    model_step(1, st.v, st.s, st.e, st.d);
    @(posedge clk);
    #1;
  endtask

  function automatic void push_frame(input int len, input int mode, input bit with_eop);
    // mode 0: all ones, 1: alternating 1,0, 2: random
    for (int p = 0; p < len; p++) begin
      logic d;
      d = (mode == 0) ? 1'b1 : (mode == 1) ? ((p % 2) == 0) : 1'($urandom);
      sq.push_back({1'b1, (p == 0), (with_eop && p == len - 1), d});
    end
  endfunction

  function automatic void push_idle(input int n);
    for (int k = 0; k < n; k++)
      sq.push_back({1'b0, 1'($urandom), 1'($urandom), 1'($urandom)});
  endfunction

  // ---------------- scenarios ----------------
  task automatic test_reset();
    rst_n = 1'b0;
    for (int c = 0; c < 3; c++) begin
      din_vld = 1'($urandom); din_sop = 1'($urandom); din_eop = 1'($urandom); din = 1'($urandom);
      @(posedge clk);
      #1;
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== 40'h0) begin
          miscompares++;
          $display("FAIL reset dut%0d cycle %0d: got %h expected %h", i, c, obs[i], 40'h0);
        end
      end
    end
    din_vld = 0; din_sop = 0; din_eop = 0; din = 0;
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_full_frame();
    sq.delete();
    push_frame(16, 1, 1);
    push_idle(2);
    foreach (sq[k]) begin
      apply(sq[k]);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== expv[i]) begin
          miscompares++;
          $display("FAIL full_frame dut%0d step %0d: got %h expected %h", i, k, obs[i], expv[i]);
        end
      end
      if (k == 15) begin
        vectors++;
        if ({dvld_a, dsop_a, deop_a, err_a, dout_a} !== {4'b1110, 16'hAAAA}) begin
          miscompares++;
          $display("FAIL full_frame_word: got %b%b%b%b %h expected 1110 aaaa",
                   dvld_a, dsop_a, deop_a, err_a, dout_a);
        end
      end
    end
  endtask

  task automatic test_random_gaps();
    sq.delete();
    // stray valid pixels without sop are ignored
    for (int k = 0; k < 3; k++) sq.push_back({1'b1, 1'b0, 1'($urandom), 1'($urandom)});
    for (int f = 0; f < 2; f++) begin
      for (int p = 0; p < 64; p++) begin
        push_idle(int'($urandom_range(0, 3)));
        sq.push_back({1'b1, (p == 0), (p == 63), (f == 0) ? 1'b1 : 1'($urandom)});
      end
      push_idle(2);
    end
    foreach (sq[k]) begin
      apply(sq[k]);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== expv[i]) begin
          miscompares++;
          $display("FAIL random_gaps dut%0d step %0d: got %h expected %h", i, k, obs[i], expv[i]);
        end
      end
    end
  endtask

  task automatic test_short_frame();
    sq.delete();
    push_frame(20, 0, 1);
    push_idle(2);
    foreach (sq[k]) begin
      apply(sq[k]);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== expv[i]) begin
          miscompares++;
          $display("FAIL short_frame dut%0d step %0d: got %h expected %h", i, k, obs[i], expv[i]);
        end
      end
      if (k == 19) begin
        vectors++;
        if ({dvld_b, deop_b, err_b, dout_b} !== {3'b111, 16'hF000}) begin
          miscompares++;
          $display("FAIL short_frame_flush: got %b%b%b %h expected 111 f000",
                   dvld_b, deop_b, err_b, dout_b);
        end
      end
    end
  endtask

  task automatic test_early_sop();
    sq.delete();
    push_frame(5, 2, 0);
    push_frame(20, 2, 1);
    push_idle(2);
    foreach (sq[k]) begin
      apply(sq[k]);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== expv[i]) begin
          miscompares++;
          $display("FAIL early_sop dut%0d step %0d: got %h expected %h", i, k, obs[i], expv[i]);
        end
      end
    end
  endtask

  task automatic test_overflow();
    sq.delete();
    push_frame(67, 2, 1);       // dut_b overflows at its 64th pixel
    push_idle(1);
    push_frame(18, 2, 0);       // dut_a overflows, then sop arrives while dropping
    push_frame(16, 2, 1);
    push_idle(2);
    foreach (sq[k]) begin
      apply(sq[k]);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== expv[i]) begin
          miscompares++;
          $display("FAIL overflow dut%0d step %0d: got %h expected %h", i, k, obs[i], expv[i]);
        end
      end
    end
  endtask

  task automatic test_sop_eop();
    sq.delete();
    sq.push_back({1'b1, 1'b1, 1'b1, 1'b1});
    push_idle(2);
    foreach (sq[k]) begin
      apply(sq[k]);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== expv[i]) begin
          miscompares++;
          $display("FAIL sop_eop dut%0d step %0d: got %h expected %h", i, k, obs[i], expv[i]);
        end
      end
      if (k == 0) begin
        vectors++;
        if ({dvld_a, dsop_a, deop_a, err_a, dout_a} !== {4'b1111, 16'h8000}) begin
          miscompares++;
          $display("FAIL sop_eop_word: got %b%b%b%b %h expected 1111 8000",
                   dvld_a, dsop_a, deop_a, err_a, dout_a);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    sq.delete();
    push_frame(7, 0, 0);
    foreach (sq[k]) apply(sq[k]);
    rst_n = 1'b0;
    #1;
    for (int c = 0; c < 3; c++) begin
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== 40'h0) begin
          miscompares++;
          $display("FAIL reset_mid dut%0d cycle %0d: got %h expected %h", i, c, obs[i], 40'h0);
        end
      end
      din_vld = 1'($urandom); din_sop = 1'($urandom); din_eop = 1'($urandom); din = 1'($urandom);
      @(posedge clk);
      #1;
    end
    rst_n = 1'b1;
    model_reset();
    sq.delete();
    push_idle(1);
    push_frame(16, 2, 1);
    push_idle(2);
    foreach (sq[k]) begin
      apply(sq[k]);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== expv[i]) begin
          miscompares++;
          $display("FAIL reset_mid_frame dut%0d step %0d: got %h expected %h", i, k, obs[i], expv[i]);
        end
      end
    end
  endtask

  task automatic test_back_to_back();
    sq.delete();
    for (int f = 0; f < 3; f++) push_frame(16, 2, 1);
    push_frame(5, 2, 1);
    sq.push_back({1'b1, 1'b1, 1'b1, 1'($urandom)});
    push_idle(2);
    foreach (sq[k]) begin
      apply(sq[k]);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== expv[i]) begin
          miscompares++;
          $display("FAIL back_to_back dut%0d step %0d: got %h expected %h", i, k, obs[i], expv[i]);
        end
      end
    end
  endtask

  initial begin
    tot[0] = 16;
    tot[1] = 64;
    model_reset();
    test_reset();
    test_full_frame();
    test_random_gaps();
    test_short_frame();
    test_early_sop();
    test_overflow();
    test_sop_eop();
    test_reset_mid();
    test_back_to_back();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
